coor_decode: RTL

- Inverse of the linear pixel-address mapping used by the display and frame buffer: addr = y*ROW_W + x, with ROW_W = 79.
- Accepts an 11-bit linear address and recovers the column x (7 bits) and row y (4 bits).
- Uses an iterative restoring divide by ROW_W, one quotient bit per clock.
- Sits between frame-buffer readback/match logic and the distance calculator. Uses valid/ready handshakes on both sides.

---
 rtl/coor_pkg.sv | 16 +
 rtl/coor_decode_if.sv | 24 ++
 rtl/coor_div_step.sv | 22 ++
 rtl/coor_decode.sv | 123 ++++++++++++
 4 files changed

// File: rtl/coor_pkg.sv
// Shared constants and state type for the linear-address to (x,y) decoder.
// Divisor, field widths and the highest address that maps onto the frame.
package coor_pkg;
    localparam int ROW_W    = 79;
    localparam int X_W      = 7;
    localparam int Y_W      = 4;
    localparam int A_W      = 11;
    localparam int ADDR_MAX = ROW_W * (2 ** Y_W) - 1;
    localparam int K_W      = (Y_W > 1) ? $clog2(Y_W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } coor_state_t;
endpackage

// File: rtl/coor_decode_if.sv
// Address-in / coordinate-out handshake bundle between the frame-buffer
// match logic (master) and the decoder (slave).
interface coor_decode_if;
    import coor_pkg::*;

    logic           in_valid;
    logic           in_ready;
    logic [A_W-1:0] in_addr;
    logic           out_valid;
    logic           out_ready;
    logic [X_W-1:0] out_x;
    logic [Y_W-1:0] out_y;
    logic           out_err;

    modport master (
        output in_valid, in_addr, out_ready,
        input  in_ready, out_valid, out_x, out_y, out_err
    );

    modport slave (
        input  in_valid, in_addr, out_ready,
        output in_ready, out_valid, out_x, out_y, out_err
    );
endinterface

// File: rtl/coor_div_step.sv
// One restoring-divide step: try to subtract ROW_W<<k from the running remainder.
module coor_div_step
    import coor_pkg::*;
(
    input  logic [A_W-1:0] rem_i,
    input  logic [K_W-1:0] k_i,
    output logic [A_W-1:0] next_rem_o,
    output logic           q_bit_o
);
    logic [A_W:0] rem_ext;
    logic [A_W:0] div_sh;
    logic [A_W:0] diff;

    // Extra bit keeps the borrow: a clear sign bit means rem >= ROW_W<<k.
    always_comb begin
        rem_ext    = {1'b0, rem_i};
        div_sh     = (A_W + 1)'(ROW_W) << k_i;
        diff       = rem_ext - div_sh;
        q_bit_o    = ~diff[A_W];
        next_rem_o = q_bit_o ? diff[A_W-1:0] : rem_i;
    end
endmodule

// File: rtl/coor_decode.sv
// Recovers (x,y) from addr = y*ROW_W + x with an iterative restoring divide,
// one quotient bit per clock, behind valid/ready handshakes on both sides.
module coor_decode
    import coor_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    coor_decode_if.slave  bus
);
    coor_state_t    state_q, state_d;
    logic [A_W-1:0] rem_q, rem_d;
    logic [Y_W-1:0] quo_q, quo_d;
    logic [K_W-1:0] k_q, k_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [X_W-1:0] out_x_q, out_x_d;
    logic [Y_W-1:0] out_y_q, out_y_d;
    logic           out_err_q, out_err_d;

    logic           accept;
    logic           addr_err;
    logic [A_W-1:0] step_rem;
    logic           step_q;
    logic [Y_W-1:0] quo_new;

    assign accept   = bus.in_valid & in_ready_q;
    assign addr_err = bus.in_addr > A_W'(ADDR_MAX);

    coor_div_step u_step (
        .rem_i      (rem_q),
        .k_i        (k_q),
        .next_rem_o (step_rem),
        .q_bit_o    (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = addr_err ? DONE : CALC;
            CALC:    if (k_q == '0) state_d = DONE;
            DONE:    if (out_valid_q && bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rem_d       = rem_q;
        quo_d       = quo_q;
        k_d         = k_q;
        out_valid_d = out_valid_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_err_d   = out_err_q;
        quo_new     = quo_q;
        quo_new[k_q] = step_q;
        in_ready_d  = (state_d == IDLE);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (addr_err) begin
                        out_err_d = 1'b1;
                        out_x_d   = '0;
                        out_y_d   = '0;
                    end else begin
                        rem_d = bus.in_addr;
                        quo_d = '0;
                        k_d   = K_W'(Y_W - 1);
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = quo_new;
                k_d   = k_q - K_W'(1);
                if (k_q == '0) begin
                    out_y_d     = quo_new;
                    out_x_d     = step_rem[X_W-1:0];
                    out_err_d   = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                // The error path arrives with out_valid low; raise it one edge later.
                if (!out_valid_q)         out_valid_d = 1'b1;
                else if (bus.out_ready)   out_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q       <= '0;
            quo_q       <= '0;
            k_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_err_q   <= 1'b0;
        end else begin
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            k_q         <= k_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_err_q   <= out_err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_x     = out_x_q;
    assign bus.out_y     = out_y_q;
    assign bus.out_err   = out_err_q;
endmodule
